pass_checker: RTL

// Password checker. Collects digits from the keypad, then reads the stored password from the 16x4 password store and compares it digit by digit.

---
 rtl/pass_keeper_pkg.sv | 30 +++
 rtl/pass_entry_buf.sv | 58 +++++
 rtl/pass_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pass_keeper_pkg.sv
// Shared definitions for the password checker: FSM states, keypad codes,
// password-store layout and small helper functions.
package pass_keeper_pkg;

    typedef enum logic [2:0] {
        ENTRY    = 3'd0,
        RD_LEN   = 3'd1,
        WAIT_LEN = 3'd2,
        RD_DIG   = 3'd3,
        WAIT_DIG = 3'd4,
        PASS     = 3'd5,
        FAIL     = 3'd6,
        LOCKOUT  = 3'd7
    } state_e;

    localparam logic [3:0] KEY_CLEAR      = 4'hA;
    localparam logic [3:0] KEY_ENTER      = 4'hB;
    localparam logic [3:0] KEY_MAX_DIGIT  = 4'h9;
    localparam logic [3:0] STORE_LEN_ADDR = 4'h0;

    // Failure counter saturates at 3 so it never wraps back to zero.
    function automatic logic [1:0] tries_inc(input logic [1:0] t);
        return (t == 2'd3) ? 2'd3 : t + 2'd1;
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= KEY_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/pass_entry_buf.sv
// Digit buffer for one password attempt: MAX_LEN x 4-bit entries, fill
// count, overflow flag and a combinational read port.
module pass_entry_buf #(
    parameter int MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [3:0] digit_i,
    input  logic [3:0] rd_idx_i,
    output logic [3:0] rd_digit_o,
    output logic [3:0] count_o,
    output logic       ovf_o
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

    logic [3:0] digits_q [MAX_LEN];
    logic [3:0] count_q;
    logic       ovf_q;

    // Append digits while there is room; a digit into a full buffer only flags overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                digits_q[k] <= 4'd0;
            end
        end else if (clr_i) begin
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
        end else if (push_i) begin
            if (count_q < MAX_LEN_C) begin
                digits_q[count_q[IDX_W-1:0]] <= digit_i;
                count_q                      <= count_q + 4'd1;
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Read port; out-of-range indices (e.g. idle index wrap) return zero.
    always_comb begin
        rd_digit_o = 4'd0;
        if (rd_idx_i < MAX_LEN_C) begin
            rd_digit_o = digits_q[rd_idx_i[IDX_W-1:0]];
        end else begin
            rd_digit_o = 4'd0;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/pass_checker.sv
// Password checker: buffers keypad digits, then reads the stored password
// (length at address 0, digits after it) and compares digit by digit.
// Drives timed unlock, a one-cycle fail pulse and a retry lockout alarm.
module pass_checker
    import pass_keeper_pkg::*;
#(
    parameter int MAX_LEN       = 8,
    parameter int MAX_TRIES     = 3,
    parameter int UNLOCK_CYCLES = 16,
    parameter int LOCK_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] mem_addr,
    output logic       mem_cs,
    input  logic [3:0] mem_data,
    output logic       busy,
    output logic       unlock,
    output logic       fail,
    output logic       alarm,
    output logic [1:0] tries
);

    localparam int TIMER_MAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO  = TIMER_W'(0);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [3:0]         MAX_LEN_C   = 4'(MAX_LEN);
    localparam logic [2:0]         MAX_TRIES_C = 3'(MAX_TRIES);

    state_e               state_q, state_d;
    logic [3:0]           len_q, len_d;
    logic [3:0]           idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [1:0]           tries_q, tries_d;
    logic [3:0]           addr_d;
    logic [3:0]           mem_addr_q;
    logic                 mem_cs_q, busy_q, unlock_q, fail_q, alarm_q;

    logic                 buf_clr_s, buf_push_s, buf_ovf_s;
    logic [3:0]           buf_count_s, buf_digit_s;

    pass_entry_buf #(.MAX_LEN(MAX_LEN)) u_entry_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (buf_clr_s),
        .push_i    (buf_push_s),
        .digit_i   (key_code),
        .rd_idx_i  (idx_q - 4'd1),
        .rd_digit_o(buf_digit_s),
        .count_o   (buf_count_s),
        .ovf_o     (buf_ovf_s)
    );

    // Next-state logic; keys are only acted on in ENTRY, so keys while busy are dropped.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        tries_d    = tries_q;
        addr_d     = mem_addr_q;
        buf_clr_s  = 1'b0;
        buf_push_s = 1'b0;
        case (state_q)
            ENTRY: begin
                if (key_valid) begin
                    if (key_code == KEY_ENTER) begin
                        state_d = RD_LEN;
                        addr_d  = STORE_LEN_ADDR;
                    end else if (key_code == KEY_CLEAR) begin
                        buf_clr_s = 1'b1;
                    end else if (is_digit(key_code)) begin
                        buf_push_s = 1'b1;
                    end else begin
                        buf_push_s = 1'b0;
                    end
                end else begin
                    state_d = ENTRY;
                end
            end
            RD_LEN: begin
                state_d = WAIT_LEN;
            end
            WAIT_LEN: begin
                len_d = mem_data;
                if ((mem_data == 4'd0) || (mem_data > MAX_LEN_C) ||
                    (mem_data != buf_count_s) || buf_ovf_s) begin
                    state_d = FAIL;
                    tries_d = tries_inc(tries_q);
                end else begin
                    idx_d   = 4'd1;
                    addr_d  = 4'd1;
                    state_d = RD_DIG;
                end
            end
            RD_DIG: begin
                state_d = WAIT_DIG;
            end
            WAIT_DIG: begin
                if (mem_data != buf_digit_s) begin
                    state_d = FAIL;
                    tries_d = tries_inc(tries_q);
                end else if (idx_q == len_q) begin
                    state_d = PASS;
                    tries_d = 2'd0;
                    timer_d = UNLOCK_LOAD;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    addr_d  = idx_q + 4'd1;
                    state_d = RD_DIG;
                end
            end
            PASS: begin
                if (timer_q == TIMER_ZERO) begin
                    state_d   = ENTRY;
                    buf_clr_s = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            FAIL: begin
                buf_clr_s = 1'b1;
                if ({1'b0, tries_q} >= MAX_TRIES_C) begin
                    state_d = LOCKOUT;
                    timer_d = LOCK_LOAD;
                end else begin
                    state_d = ENTRY;
                end
            end
            LOCKOUT: begin
                if (timer_q == TIMER_ZERO) begin
                    state_d = ENTRY;
                    tries_d = 2'd0;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    // FSM state, latched length, digit index, timer and failure counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTRY;
            len_q   <= 4'd0;
            idx_q   <= 4'd0;
            timer_q <= TIMER_ZERO;
            tries_q <= 2'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            tries_q <= tries_d;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q <= 4'd0;
            mem_cs_q   <= 1'b0;
            busy_q     <= 1'b0;
            unlock_q   <= 1'b0;
            fail_q     <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            mem_addr_q <= addr_d;
            mem_cs_q   <= (state_d == RD_LEN) || (state_d == RD_DIG);
            busy_q     <= (state_d != ENTRY);
            unlock_q   <= (state_d == PASS);
            fail_q     <= (state_d == FAIL);
            alarm_q    <= (state_d == LOCKOUT);
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_cs   = mem_cs_q;
    assign busy     = busy_q;
    assign unlock   = unlock_q;
    assign fail     = fail_q;
    assign alarm    = alarm_q;
    assign tries    = tries_q;

endmodule
